// File: rtl/fp16_operand_unpack_pkg.sv
// Shared float16 definitions used by the operand unpacker and the product packer.
// Holds the one-hot type codes, field widths and the unpacked operand record.
package fp16_operand_unpack_pkg;

  localparam int EXP_BIAS = 15;
  localparam int EXP_W    = 7;
  localparam int SIG_W    = 11;
  localparam int TYPE_W   = 6;

  localparam logic [TYPE_W-1:0] TYPE_ZERO    = 6'b000001;
  localparam logic [TYPE_W-1:0] TYPE_INF     = 6'b000010;
  localparam logic [TYPE_W-1:0] TYPE_QNAN    = 6'b000100;
  localparam logic [TYPE_W-1:0] TYPE_SNAN    = 6'b001000;
  localparam logic [TYPE_W-1:0] TYPE_SUBNORM = 6'b010000;
  localparam logic [TYPE_W-1:0] TYPE_NORMAL  = 6'b100000;

  // Exponent of a subnormal whose fraction MSB is set (after normalizing),
  // and the fixed exponent used when subnormals are passed through raw.
  localparam logic [EXP_W-1:0] EXP_SUBN_TOP   = EXP_W'(-EXP_BIAS);
  localparam logic [EXP_W-1:0] EXP_SUBN_FIXED = EXP_W'(1 - EXP_BIAS);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
    logic [TYPE_W-1:0] typ;
  } fp16_unpacked_t;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic              sign;
    logic [4:0]        exp_raw;
    logic [9:0]        frac;
    logic [3:0]        lz;
  } fp16_fields_t;

endpackage

// File: rtl/fp16_classify_lzc.sv
// Combinational per-operand front end: splits a binary16 word into its raw
// fields, classifies it one-hot and counts leading zeros of the fraction.
module fp16_classify_lzc
  import fp16_operand_unpack_pkg::*;
(
  input  logic [15:0]  x,
  output fp16_fields_t fields
);

  logic [4:0] e;
  logic [9:0] f;
  logic [3:0] lz;

  assign e = x[14:10];
  assign f = x[9:0];

  // Highest set bit wins; an all-zero fraction reports 10.
  always_comb begin
    lz = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (f[i]) lz = 4'(9 - i);
    end
  end

  always_comb begin
    fields         = '0;
    fields.sign    = x[15];
    fields.exp_raw = e;
    fields.frac    = f;
    fields.lz      = lz;
    if (e == 5'd0) begin
      fields.typ = (f == 10'd0) ? TYPE_ZERO : TYPE_SUBNORM;
    end else if (e == 5'd31) begin
      if (f == 10'd0)  fields.typ = TYPE_INF;
      else if (f[9])   fields.typ = TYPE_QNAN;
      else             fields.typ = TYPE_SNAN;
    end else begin
      fields.typ = TYPE_NORMAL;
    end
  end

endmodule

// File: rtl/fp16_operand_unpack.sv
// Two-stage binary16 operand-pair unpacker with valid/ready backpressure:
// S1 classifies and counts leading zeros, S2 produces the final EXP/SIG.
module fp16_operand_unpack
  import fp16_operand_unpack_pkg::*;
#(
  parameter int NORM_SUBNORM = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [15:0]       A,
  input  logic [15:0]       B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [TYPE_W-1:0] A_TYPE,
  output logic [TYPE_W-1:0] B_TYPE,
  output logic              A_SIGN,
  output logic              B_SIGN,
  output logic [EXP_W-1:0]  A_EXP,
  output logic [EXP_W-1:0]  B_EXP,
  output logic [SIG_W-1:0]  A_SIG,
  output logic [SIG_W-1:0]  B_SIG
);

  logic [15:0]    opnd   [2];
  fp16_fields_t   cls    [2];
  fp16_fields_t   s1_reg [2];
  fp16_unpacked_t s2_reg [2];
  logic           s1_v_reg;
  logic           s2_v_reg;
  logic           s1_load;
  logic           s2_load;

  assign opnd[0] = A;
  assign opnd[1] = B;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cls
      fp16_classify_lzc u_cls (
        .x      (opnd[gi]),
        .fields (cls[gi])
      );
    end
  endgenerate

  function automatic fp16_unpacked_t normalize(input fp16_fields_t f);
    fp16_unpacked_t r;
    logic [SIG_W-1:0] shifted;
    r       = '0;
    r.sign  = f.sign;
    r.typ   = f.typ;
    shifted = {f.frac, 1'b0} << f.lz;
    if (f.typ == TYPE_NORMAL) begin
      r.exp = {2'b00, f.exp_raw} - EXP_W'(EXP_BIAS);
      r.sig = {1'b1, f.frac};
    end else if (f.typ == TYPE_SUBNORM) begin
      if (NORM_SUBNORM != 0) begin
        r.exp = EXP_SUBN_TOP - {3'b000, f.lz};
        r.sig = shifted;
      end else begin
        r.exp = EXP_SUBN_FIXED;
        r.sig = {1'b0, f.frac};
      end
    end else if (f.typ == TYPE_QNAN || f.typ == TYPE_SNAN) begin
      r.sig = {1'b0, f.frac};
    end
    return r;
  endfunction

  // S2 drains when empty or accepted downstream; S1 drains into a draining S2.
  assign s2_load  = !s2_v_reg || OUT_READY;
  assign s1_load  = !s1_v_reg || s2_load;
  assign IN_READY = s1_load;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_v_reg <= 1'b0;
      s2_v_reg <= 1'b0;
    end else begin
      if (s1_load) s1_v_reg <= IN_VALID;
      if (s2_load) s2_v_reg <= s1_v_reg;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 2; i++) begin
        s1_reg[i] <= '0;
        s2_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s1_load && IN_VALID) s1_reg[i] <= cls[i];
        if (s2_load && s1_v_reg) s2_reg[i] <= normalize(s1_reg[i]);
      end
    end
  end

  assign OUT_VALID = s2_v_reg;
  assign A_TYPE    = s2_reg[0].typ;
  assign A_SIGN    = s2_reg[0].sign;
  assign A_EXP     = s2_reg[0].exp;
  assign A_SIG     = s2_reg[0].sig;
  assign B_TYPE    = s2_reg[1].typ;
  assign B_SIGN    = s2_reg[1].sign;
  assign B_EXP     = s2_reg[1].exp;
  assign B_SIG     = s2_reg[1].sig;

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// Directed bench for the binary16 operand unpacker: values, specials,
// backpressure, full-rate streaming and mid-stream reset.
module tb_fp16_operand_unpack;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;

  logic        IN_READY, OUT_VALID;
  logic [5:0]  A_TYPE, B_TYPE;
  logic        A_SIGN, B_SIGN;
  logic [6:0]  A_EXP, B_EXP;
  logic [10:0] A_SIG, B_SIG;

  logic        n0_in_ready, n0_out_valid;
  logic [5:0]  n0_a_type, n0_b_type;
  logic        n0_a_sign, n0_b_sign;
  logic [6:0]  n0_a_exp, n0_b_exp;
  logic [10:0] n0_a_sig, n0_b_sig;

  fp16_operand_unpack #(.NORM_SUBNORM(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .A_TYPE(A_TYPE), .B_TYPE(B_TYPE), .A_SIGN(A_SIGN), .B_SIGN(B_SIGN),
    .A_EXP(A_EXP), .B_EXP(B_EXP), .A_SIG(A_SIG), .B_SIG(B_SIG)
  );

  fp16_operand_unpack #(.NORM_SUBNORM(0)) dut_raw (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(n0_in_ready),
    .A(A), .B(B), .OUT_VALID(n0_out_valid), .OUT_READY(OUT_READY),
    .A_TYPE(n0_a_type), .B_TYPE(n0_b_type), .A_SIGN(n0_a_sign), .B_SIGN(n0_b_sign),
    .A_EXP(n0_a_exp), .B_EXP(n0_b_exp), .A_SIG(n0_a_sig), .B_SIG(n0_b_sig)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  logic [24:0] a_obs, b_obs, a0_obs;
  assign a_obs  = {A_TYPE, A_SIGN, A_EXP, A_SIG};
  assign b_obs  = {B_TYPE, B_SIGN, B_EXP, B_SIG};
  assign a0_obs = {n0_a_type, n0_a_sign, n0_a_exp, n0_a_sig};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] opv(input logic [5:0] t, input logic s,
                                      input logic [6:0] e, input logic [10:0] g);
    return {t, s, e, g};
  endfunction

  // One pair through an idle pipe; result appears two edges after acceptance.
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [24:0] ea, input logic [24:0] eb, input logic [24:0] ea0);
    IN_VALID = 1'b1; A = a; B = b; OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk({tag, ".lat1_valid"}, 64'(OUT_VALID), 64'd0);
    @(negedge CLK);
    chk({tag, ".valid"}, 64'(OUT_VALID), 64'd1);
    chk({tag, ".a"}, 64'(a_obs), 64'(ea));
    chk({tag, ".b"}, 64'(b_obs), 64'(eb));
    chk({tag, ".a_raw"}, 64'(a0_obs), 64'(ea0));
  endtask

  // Stream pair k: A = 1.0 with fraction k, B = -4.0 with fraction k<<3.
  logic [49:0] exp_q[$];
  int sent = 0;
  int n_send = 0;
  int rcv = 0;

  function automatic logic [49:0] stream_exp(input int k);
    return {6'b100000, 1'b0, 7'd0, 11'h400 | 11'(k),
            6'b100000, 1'b1, 7'd2, 11'h400 | 11'(k << 3)};
  endfunction

  task automatic step(input logic ordy, output bit acc, output bit emit, output bit ir);
    logic [49:0] e;
    OUT_READY = ordy;
    IN_VALID  = (sent < n_send);
    A = 16'h3C00 | 16'(sent);
    B = 16'hC400 | 16'(sent << 3);
    #1;
    ir   = IN_READY;
    acc  = IN_VALID && IN_READY;
    emit = OUT_VALID && OUT_READY;
    if (emit) begin
      rcv++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("stream.pair%0d", rcv), 64'({a_obs, b_obs}), 64'(e));
      end
    end
    if (acc) begin
      exp_q.push_back(stream_exp(sent));
      sent++;
    end
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc, emit, ir;
    int accs, first, last, rcv0;
    logic [50:0] snap;

    repeat (3) @(negedge CLK);
    chk("reset.out_valid", 64'(OUT_VALID), 64'd0);
    chk("reset.in_ready", 64'(IN_READY), 64'd1);
    chk("reset.a_data", 64'(a_obs), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("release.out_valid", 64'(OUT_VALID), 64'd0);
    chk("release.in_ready", 64'(IN_READY), 64'd1);

    send_one("basic", 16'h3C00, 16'hC000,
             opv(6'b100000, 1'b0, 7'd0, 11'h400), opv(6'b100000, 1'b1, 7'd1, 11'h400),
             opv(6'b100000, 1'b0, 7'd0, 11'h400));
    send_one("subn", 16'h0001, 16'h0200,
             opv(6'b010000, 1'b0, 7'h68, 11'h400), opv(6'b010000, 1'b0, 7'h71, 11'h400),
             opv(6'b010000, 1'b0, 7'h72, 11'h001));
    send_one("inf_qnan", 16'h7C00, 16'h7E00,
             opv(6'b000010, 1'b0, 7'd0, 11'h000), opv(6'b000100, 1'b0, 7'd0, 11'h200),
             opv(6'b000010, 1'b0, 7'd0, 11'h000));
    send_one("snan_nzero", 16'h7C01, 16'h8000,
             opv(6'b001000, 1'b0, 7'd0, 11'h001), opv(6'b000001, 1'b1, 7'd0, 11'h000),
             opv(6'b001000, 1'b0, 7'd0, 11'h001));
    send_one("max_subn", 16'h7BFF, 16'h8155,
             opv(6'b100000, 1'b0, 7'h0F, 11'h7FF), opv(6'b010000, 1'b1, 7'h70, 11'h554),
             opv(6'b100000, 1'b0, 7'h0F, 11'h7FF));
    @(negedge CLK);

    // Backpressure: 8 pairs, OUT_READY low for the first 5 cycles.
    n_send = 8; accs = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, acc, emit, ir);
      if (acc) accs++;
      if (c >= 2) chk("bp.in_ready_low", 64'(ir), 64'd0);
      if (c == 1) begin
        snap = {OUT_VALID, a_obs, b_obs};
        chk("bp.valid_stalled", 64'(OUT_VALID), 64'd1);
      end
      if (c >= 2) chk("bp.hold", 64'({OUT_VALID, a_obs, b_obs}), 64'(snap));
    end
    chk("bp.accepts", 64'(accs), 64'd2);
    for (int c = 0; c < 40 && rcv < 8; c++) step(1'b1, acc, emit, ir);
    chk("bp.received", 64'(rcv), 64'd8);
    chk("bp.queue_empty", 64'(exp_q.size()), 64'd0);

    // Full throughput: 16 pairs back to back.
    n_send = sent + 16; rcv0 = rcv; accs = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && rcv < rcv0 + 16; c++) begin
      step(1'b1, acc, emit, ir);
      if (emit) begin
        if (first < 0) first = c;
        last = c;
      end
      if (c < 16 && acc) accs++;
    end
    chk("tp.accepts", 64'(accs), 64'd16);
    chk("tp.received", 64'(rcv - rcv0), 64'd16);
    chk("tp.no_bubble", 64'(last - first + 1), 64'd16);
    chk("tp.first_latency", 64'(first), 64'd2);

    // Reset with two pairs in flight.
    n_send = sent + 2;
    step(1'b0, acc, emit, ir);
    step(1'b0, acc, emit, ir);
    chk("rst.valid_before", 64'(OUT_VALID), 64'd1);
    RSTn = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("rst.valid_now", 64'(OUT_VALID), 64'd0);
    chk("rst.a_type", 64'(A_TYPE), 64'd0);
    exp_q.delete();
    sent = n_send;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1; OUT_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("rst.no_stale", 64'(OUT_VALID), 64'd0);
    end
    send_one("recover", 16'h3C00, 16'hC000,
             opv(6'b100000, 1'b0, 7'd0, 11'h400), opv(6'b100000, 1'b1, 7'd1, 11'h400),
             opv(6'b100000, 1'b0, 7'd0, 11'h400));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
